// File: rtl/mem_resp_pkg.sv
// Shared types and default widths for the memory request responder.
//   mem_state_t : responder FSM states (IDLE, ACCESS, RESP)
//   req_src_t   : which core port owns the in-flight transaction
package mem_resp_pkg;

   localparam int unsigned DEF_ADDR_W  = 32;
   localparam int unsigned DEF_DATA_W  = 32;
   localparam int unsigned DEF_TIMEOUT = 15;

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} mem_state_t;

   typedef enum logic {REQ_INSTR, REQ_DATA} req_src_t;

endpackage

// File: rtl/mem_timeout_ctr.sv
// Saturating ACCESS-cycle counter with synchronous clear.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   clr_i      : force count to zero (takes priority over en_i)
//   en_i       : count one cycle; holds at TIMEOUT-1
//   done_c_o   : combinational, high while count == TIMEOUT-1
module mem_timeout_ctr #(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic clk,
   input  logic reset,
   input  logic clr_i,
   input  logic en_i,
   output logic done_c_o
);

   localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Next count: clear wins, otherwise count up and stick at LAST.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && (cnt_q != LAST)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign done_c_o = (cnt_q == LAST);

endmodule

// File: rtl/mem_req_responder.sv
// Memory-side responder: serialises instruction-fetch and data requests
// from a single-cycle core onto one variable-latency single-ported RAM
// and answers each with a one-cycle ready pulse.
// Ports:
//   clk, reset                        : clock, asynchronous active-high reset
//   imem_req/imem_addr                : fetch request (held until i_ready)
//   imem_rdata, i_ready               : fetch data and completion pulse
//   dmem_ren/dmem_wen/dmem_addr/wdata : data request (wen wins over ren)
//   dmem_rdata, d_ready               : load data and completion pulse
//   ram_ren/ram_wen/ram_addr/wdata    : RAM strobes and payload
//   ram_rdata, ram_ready              : RAM return data and completion
//   mem_err                           : error flag, coincident with a ready
// Build option: MEM_MISALIGN_CHECK_EN rejects addresses with addr[1:0]!=0
// without touching the RAM.
module mem_req_responder
   import mem_resp_pkg::*;
#(
   parameter int unsigned ADDR_W  = DEF_ADDR_W,
   parameter int unsigned DATA_W  = DEF_DATA_W,
   parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              imem_req,
   input  logic [ADDR_W-1:0] imem_addr,
   output logic [DATA_W-1:0] imem_rdata,
   output logic              i_ready,
   input  logic              dmem_ren,
   input  logic              dmem_wen,
   input  logic [ADDR_W-1:0] dmem_addr,
   input  logic [DATA_W-1:0] dmem_wdata,
   output logic [DATA_W-1:0] dmem_rdata,
   output logic              d_ready,
   output logic              ram_ren,
   output logic              ram_wen,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   input  logic              ram_ready,
   output logic              mem_err
);

   mem_state_t        state_q, state_d;
   req_src_t          src_q, src_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              ren_q, ren_d;
   logic              wen_q, wen_d;
   logic [DATA_W-1:0] irdata_q, irdata_d;
   logic [DATA_W-1:0] drdata_q, drdata_d;
   logic              iready_q, iready_d;
   logic              dready_q, dready_d;
   logic              err_q, err_d;
   logic              to_done_c;

   // Counts ACCESS cycles; cleared while idle so each access starts at zero.
   mem_timeout_ctr #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk      (clk),
      .reset    (reset),
      .clr_i    (state_q == IDLE),
      .en_i     (state_q == ACCESS),
      .done_c_o (to_done_c)
   );

   // Next-state and registered-output logic. Strobes and ready pulses
   // default low so they only exist in the state that owns them.
   always_comb begin
      state_d  = state_q;
      src_d    = src_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      ren_d    = 1'b0;
      wen_d    = 1'b0;
      irdata_d = irdata_q;
      drdata_d = drdata_q;
      iready_d = 1'b0;
      dready_d = 1'b0;
      err_d    = 1'b0;

      case (state_q)
         IDLE: begin
            // Data port has priority over fetch.
            if (dmem_wen || dmem_ren) begin
               src_d   = REQ_DATA;
               addr_d  = dmem_addr;
               wdata_d = dmem_wdata;
               wen_d   = dmem_wen;
               ren_d   = ~dmem_wen;
               state_d = ACCESS;
            end else if (imem_req) begin
               src_d   = REQ_INSTR;
               addr_d  = imem_addr;
               ren_d   = 1'b1;
               state_d = ACCESS;
            end
`ifdef MEM_MISALIGN_CHECK_EN
            // Misaligned: answer with an error without touching the RAM.
            if ((state_d == ACCESS) && (addr_d[1:0] != 2'b00)) begin
               ren_d    = 1'b0;
               wen_d    = 1'b0;
               err_d    = 1'b1;
               iready_d = (src_d == REQ_INSTR);
               dready_d = (src_d == REQ_DATA);
               state_d  = RESP;
            end
`endif
         end

         ACCESS: begin
            // ram_ready on the final count beats the abort.
            if (ram_ready) begin
               if (ren_q) begin
                  if (src_q == REQ_INSTR) begin
                     irdata_d = ram_rdata;
                  end else begin
                     drdata_d = ram_rdata;
                  end
               end
               iready_d = (src_q == REQ_INSTR);
               dready_d = (src_q == REQ_DATA);
               state_d  = RESP;
            end else if (to_done_c) begin
               err_d    = 1'b1;
               iready_d = (src_q == REQ_INSTR);
               dready_d = (src_q == REQ_DATA);
               state_d  = RESP;
            end else begin
               ren_d = ren_q;
               wen_d = wen_q;
            end
         end

         RESP: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         src_q    <= REQ_INSTR;
         addr_q   <= '0;
         wdata_q  <= '0;
         ren_q    <= 1'b0;
         wen_q    <= 1'b0;
         irdata_q <= '0;
         drdata_q <= '0;
         iready_q <= 1'b0;
         dready_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         src_q    <= src_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         ren_q    <= ren_d;
         wen_q    <= wen_d;
         irdata_q <= irdata_d;
         drdata_q <= drdata_d;
         iready_q <= iready_d;
         dready_q <= dready_d;
         err_q    <= err_d;
      end
   end

   assign imem_rdata = irdata_q;
   assign i_ready    = iready_q;
   assign dmem_rdata = drdata_q;
   assign d_ready    = dready_q;
   assign ram_ren    = ren_q;
   assign ram_wen    = wen_q;
   assign ram_addr   = addr_q;
   assign ram_wdata  = wdata_q;
   assign mem_err    = err_q;

endmodule

// File: tb/tb_mem_req_responder.sv
// Self-checking bench for mem_req_responder: directed scenarios plus
// randomized episodes against a transaction-level timeline model.
`timescale 1ns/1ps
module tb_mem_req_responder;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int TO = 15;

   logic          clk = 1'b0;
   logic          reset;
   logic          imem_req;
   logic [AW-1:0] imem_addr;
   logic [DW-1:0] imem_rdata;
   logic          i_ready;
   logic          dmem_ren;
   logic          dmem_wen;
   logic [AW-1:0] dmem_addr;
   logic [DW-1:0] dmem_wdata;
   logic [DW-1:0] dmem_rdata;
   logic          d_ready;
   logic          ram_ren;
   logic          ram_wen;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_wdata;
   logic [DW-1:0] ram_rdata;
   logic          ram_ready;
   logic          mem_err;

   always #5 clk = ~clk;

   mem_req_responder #(
      .ADDR_W  (AW),
      .DATA_W  (DW),
      .TIMEOUT (TO)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_rdata (imem_rdata),
      .i_ready    (i_ready),
      .dmem_ren   (dmem_ren),
      .dmem_wen   (dmem_wen),
      .dmem_addr  (dmem_addr),
      .dmem_wdata (dmem_wdata),
      .dmem_rdata (dmem_rdata),
      .d_ready    (d_ready),
      .ram_ren    (ram_ren),
      .ram_wen    (ram_wen),
      .ram_addr   (ram_addr),
      .ram_wdata  (ram_wdata),
      .ram_rdata  (ram_rdata),
      .ram_ready  (ram_ready),
      .mem_err    (mem_err)
   );

   int checks   = 0;
   int failures = 0;

   // Model state: held read data and the outputs expected this cycle.
   logic [31:0] m_irdata, m_drdata;
   logic        e_ren, e_wen, e_iready, e_dready, e_err;
   logic [31:0] e_addr, e_wdata;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
      end
   endtask

   task automatic set_idle();
      e_ren = 1'b0; e_wen = 1'b0;
      e_iready = 1'b0; e_dready = 1'b0; e_err = 1'b0;
   endtask

   // The single per-cycle comparison point, sampled on the falling edge.
   task automatic step();
      @(negedge clk);
      chk("ram_ren", 32'(ram_ren), 32'(e_ren));
      chk("ram_wen", 32'(ram_wen), 32'(e_wen));
      chk("i_ready", 32'(i_ready), 32'(e_iready));
      chk("d_ready", 32'(d_ready), 32'(e_dready));
      chk("mem_err", 32'(mem_err), 32'(e_err));
      chk("imem_rdata", imem_rdata, m_irdata);
      chk("dmem_rdata", dmem_rdata, m_drdata);
      if (e_ren || e_wen) chk("ram_addr", ram_addr, e_addr);
      if (e_wen) chk("ram_wdata", ram_wdata, e_wdata);
   endtask

   // One transaction from the cycle after its IDLE cycle through RESP.
   // lat = cycle of ACCESS on which the RAM answers (>TO means never).
   task automatic serve(input bit is_data, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input int lat, input logic [31:0] rv);
      bit mis;
      bit err;
      int n;
      mis = 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
      mis = (addr[1:0] != 2'b00);
`endif
      n = (lat < TO) ? lat : TO;
      if (!mis) begin
         for (int j = 1; j <= n; j++) begin
            e_ren = ~wr; e_wen = wr; e_addr = addr; e_wdata = wdata;
            step();
            ram_ready = (j == lat);
            ram_rdata = (j == lat) ? rv : $urandom();
            // Served-side core inputs wander; the transaction must not care.
            if (is_data) begin
               dmem_addr  = $urandom();
               dmem_wdata = $urandom();
               if ($urandom_range(0, 3) == 0) begin dmem_ren = 1'b0; dmem_wen = 1'b0; end
            end else begin
               imem_addr = $urandom();
               if ($urandom_range(0, 3) == 0) imem_req = 1'b0;
            end
         end
      end
      err = mis || (lat > TO);
      if (!err && !wr) begin
         if (is_data) m_drdata = rv; else m_irdata = rv;
      end
      e_ren = 1'b0; e_wen = 1'b0;
      e_iready = ~is_data; e_dready = is_data; e_err = err;
      step();
      ram_ready = 1'b0;
      if (is_data) begin dmem_ren = 1'b0; dmem_wen = 1'b0; end
      else imem_req = 1'b0;
      set_idle();
   endtask

   // IDLE cycle with the requests raised, then data first, fetch second.
   task automatic episode(input bit want_i, input logic [31:0] ia, input int li, input logic [31:0] iv,
                          input bit want_d, input bit dwr, input logic [31:0] da,
                          input logic [31:0] dwd, input int ld, input logic [31:0] dv);
      step();
      imem_req   = want_i;
      imem_addr  = ia;
      dmem_wen   = want_d && dwr;
      dmem_ren   = want_d && (!dwr || ($urandom_range(0, 1) == 1));
      dmem_addr  = da;
      dmem_wdata = dwd;
      if (want_d) begin
         serve(1'b1, dwr, da, dwd, ld, dv);
         if (want_i) step();
      end
      if (want_i) serve(1'b0, 1'b0, ia, 32'h0, li, iv);
   endtask

   initial begin
      reset = 1'b1;
      imem_req = 1'b0; imem_addr = '0;
      dmem_ren = 1'b0; dmem_wen = 1'b0; dmem_addr = '0; dmem_wdata = '0;
      ram_rdata = '0; ram_ready = 1'b0;
      m_irdata = '0; m_drdata = '0;
      e_addr = '0; e_wdata = '0;
      set_idle();

      repeat (2) @(negedge clk);
      chk("rst_ram_ren", 32'(ram_ren), 32'h0);
      chk("rst_i_ready", 32'(i_ready), 32'h0);
      chk("rst_imem_rdata", imem_rdata, 32'h0);
      chk("rst_dmem_rdata", dmem_rdata, 32'h0);
      reset = 1'b0;

      // Single fetch, RAM answers immediately.
      episode(1'b1, 32'h4, 1, 32'h0050_0093, 1'b0, 1'b0, 32'h0, 32'h0, 1, 32'h0);
      chk("fetch_lit", imem_rdata, 32'h0050_0093);

      // Simultaneous fetch and load: load served first.
      episode(1'b1, 32'h8, 1, 32'h1234_5678, 1'b1, 1'b0, 32'h20, 32'h0, 1, 32'hDEAD_BEEF);
      chk("prio_d_lit", dmem_rdata, 32'hDEAD_BEEF);
      chk("prio_i_lit", imem_rdata, 32'h1234_5678);

      // Store with four ACCESS cycles; load data must not move.
      episode(1'b0, 32'h0, 1, 32'h0, 1'b1, 1'b1, 32'h10, 32'hCAFE_F00D, 4, 32'h5555_AAAA);
      chk("store_lit", dmem_rdata, 32'hDEAD_BEEF);

      // RAM never answers: abort after TO cycles, data unchanged.
      episode(1'b0, 32'h0, 1, 32'h0, 1'b1, 1'b0, 32'h30, 32'h0, TO + 1, 32'h0BAD_0BAD);
      chk("timeout_lit", dmem_rdata, 32'hDEAD_BEEF);

      // RAM answers on the final count: success, not abort.
      episode(1'b0, 32'h0, 1, 32'h0, 1'b1, 1'b0, 32'h34, 32'h0, TO, 32'hA5A5_0001);
      chk("lastcount_lit", dmem_rdata, 32'hA5A5_0001);

      // Async reset in the second ACCESS cycle of a load.
      step();
      dmem_ren = 1'b1; dmem_addr = 32'h40;
      e_ren = 1'b1; e_addr = 32'h40;
      step();
      step();
      #1 reset = 1'b1;
      #1;
      chk("midrst_ram_ren", 32'(ram_ren), 32'h0);
      chk("midrst_d_ready", 32'(d_ready), 32'h0);
      chk("midrst_dmem_rdata", dmem_rdata, 32'h0);
      dmem_ren = 1'b0;
      m_irdata = '0; m_drdata = '0;
      set_idle();
      #1 reset = 1'b0;
      repeat (3) step();
      episode(1'b1, 32'hC, 2, 32'h00A0_0113, 1'b0, 1'b0, 32'h0, 32'h0, 1, 32'h0);
      chk("postrst_lit", imem_rdata, 32'h00A0_0113);

`ifdef MEM_MISALIGN_CHECK_EN
      episode(1'b0, 32'h0, 1, 32'h0, 1'b1, 1'b0, 32'h6, 32'h0, 1, 32'h7777_7777);
      chk("misalign_lit", dmem_rdata, 32'h0);
`endif

      // Randomized episodes.
      for (int k = 0; k < 80; k++) begin
         bit wi, wd, wr;
         int li, ld;
         wi = ($urandom_range(0, 2) != 0);
         wd = ($urandom_range(0, 2) != 0);
         wr = ($urandom_range(0, 2) == 0);
         li = ($urandom_range(0, 3) == 0) ? 1 : $urandom_range(1, TO + 2);
         ld = ($urandom_range(0, 3) == 0) ? 1 : $urandom_range(1, TO + 2);
         episode(wi, $urandom(), li, $urandom(), wd, wr, $urandom(), $urandom(), ld, $urandom());
         repeat ($urandom_range(0, 2)) step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
